// File: rtl/strip_alloc_ctrl.sv
// strip_alloc_ctrl: allocate/free controller for the strip occupancy RAM.
// RAM entry 0 holds strip capacity and is only read; entries 1..NUM_STRIPS
// hold the used amount per strip. Occupancy is read three strips per group.
// Build option: STRIP_ALLOC_BEST_FIT_EN selects best-fit allocation (every
// group is scanned, the smallest leftover wins, ties to the lowest strip);
// when undefined, the lowest fitting strip wins (first fit).
module strip_alloc_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_STRIPS = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [DATA_WIDTH-1:0] req_size,
    input  logic [ADDR_WIDTH-1:0] req_strip,
    output logic                  resp_valid,
    output logic                  resp_ok,
    output logic [ADDR_WIDTH-1:0] resp_strip,
    output logic [DATA_WIDTH-1:0] resp_used,
    output logic                  ram_read_en,
    output logic [ADDR_WIDTH-1:0] ram_addr_read1,
    output logic [ADDR_WIDTH-1:0] ram_addr_read2,
    output logic [ADDR_WIDTH-1:0] ram_addr_read3,
    input  logic [DATA_WIDTH-1:0] ram_data_out1,
    input  logic [DATA_WIDTH-1:0] ram_data_out2,
    input  logic [DATA_WIDTH-1:0] ram_data_out3,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_addr_write,
    output logic [DATA_WIDTH-1:0] ram_data_in
);

    // Group base and lane addresses run past NUM_STRIPS, so they carry one extra bit.
    localparam int unsigned GW    = ADDR_WIDTH + 1;
    // Occupancy sums are formed one bit wider so used+size never wraps.
    localparam int unsigned SW    = DATA_WIDTH + 1;
    localparam int unsigned LANES = 3;
    localparam logic [GW-1:0] LAST_STRIP = GW'(NUM_STRIPS);
    localparam logic [GW-1:0] FIRST_BASE = GW'(1);
    localparam logic [GW-1:0] GROUP_STEP = GW'(LANES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAP_RD,
        S_CAP_WT,
        S_RD,
        S_EVAL,
        S_ADV,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                  state_q;
    logic                    op_q;
    logic [DATA_WIDTH-1:0]   size_q;
    logic [ADDR_WIDTH-1:0]   strip_q;
    logic [GW-1:0]           g_q;
    logic [DATA_WIDTH-1:0]   cap_q;
    logic                    cap_valid_q;
    logic                    found_q;
    logic [ADDR_WIDTH-1:0]   sel_strip_q;
    logic [DATA_WIDTH-1:0]   sel_used_q;
`ifdef STRIP_ALLOC_BEST_FIT_EN
    logic [SW-1:0]           best_left_q;
`endif

    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic                    resp_ok_q;
    logic [ADDR_WIDTH-1:0]   resp_strip_q;
    logic [DATA_WIDTH-1:0]   resp_used_q;
    logic                    rd_en_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q [LANES];
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    logic [DATA_WIDTH-1:0]   rd_data_c   [LANES];
    logic [GW-1:0]           lane_addr_c [LANES];
    logic [SW-1:0]           lane_sum_c  [LANES];
    logic [LANES-1:0]        lane_fit_c;
    logic                    any_fit_c;
    logic [GW-1:0]           pick_addr_c;
    logic [SW-1:0]           pick_sum_c;
`ifdef STRIP_ALLOC_BEST_FIT_EN
    logic [SW-1:0]           lane_left_c [LANES];
    logic [SW-1:0]           pick_left_c;
    logic                    take_best_c;
`endif
    logic [DATA_WIDTH-1:0]   free_new_c;
    logic [GW-1:0]           g_next_c;

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_ok        = resp_ok_q;
    assign resp_strip     = resp_strip_q;
    assign resp_used      = resp_used_q;
    assign ram_read_en    = rd_en_q;
    assign ram_addr_read1 = rd_addr_q[0];
    assign ram_addr_read2 = rd_addr_q[1];
    assign ram_addr_read3 = rd_addr_q[2];
    assign ram_write_en   = wr_en_q;
    assign ram_addr_write = wr_addr_q;
    assign ram_data_in    = wr_data_q;

    // RAM read address of one lane of a group; lanes past the last strip read 0.
    function automatic logic [ADDR_WIDTH-1:0] lane_ram_addr(input logic [GW-1:0] base,
                                                            input int lane);
        logic [GW-1:0] a;
        a = base + GW'(lane);
        return (a <= LAST_STRIP) ? ADDR_WIDTH'(a) : '0;
    endfunction

    // Lane evaluation: fit test per lane, pick the winning lane of this group.
    always_comb begin
        rd_data_c[0] = ram_data_out1;
        rd_data_c[1] = ram_data_out2;
        rd_data_c[2] = ram_data_out3;
        any_fit_c    = 1'b0;
        pick_addr_c  = '0;
        pick_sum_c   = '0;
`ifdef STRIP_ALLOC_BEST_FIT_EN
        pick_left_c  = '0;
`endif
        for (int i = 0; i < int'(LANES); i++) begin
            lane_addr_c[i] = g_q + GW'(i);
            lane_sum_c[i]  = SW'(rd_data_c[i]) + SW'(size_q);
            lane_fit_c[i]  = (lane_addr_c[i] <= LAST_STRIP) && (lane_sum_c[i] <= SW'(cap_q));
`ifdef STRIP_ALLOC_BEST_FIT_EN
            lane_left_c[i] = SW'(cap_q) - lane_sum_c[i];
            if (lane_fit_c[i] && (!any_fit_c || (lane_left_c[i] < pick_left_c))) begin
                any_fit_c   = 1'b1;
                pick_addr_c = lane_addr_c[i];
                pick_sum_c  = lane_sum_c[i];
                pick_left_c = lane_left_c[i];
            end
`else
            if (lane_fit_c[i] && !any_fit_c) begin
                any_fit_c   = 1'b1;
                pick_addr_c = lane_addr_c[i];
                pick_sum_c  = lane_sum_c[i];
            end
`endif
        end
`ifdef STRIP_ALLOC_BEST_FIT_EN
        take_best_c = any_fit_c && (!found_q || (pick_left_c < best_left_q));
`endif
        free_new_c = (ram_data_out1 > size_q) ? (ram_data_out1 - size_q) : '0;
        g_next_c   = g_q + GROUP_STEP;
    end

    // Control FSM with registered RAM and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 1'b0;
            size_q       <= '0;
            strip_q      <= '0;
            g_q          <= '0;
            cap_q        <= '0;
            cap_valid_q  <= 1'b0;
            found_q      <= 1'b0;
            sel_strip_q  <= '0;
            sel_used_q   <= '0;
`ifdef STRIP_ALLOC_BEST_FIT_EN
            best_left_q  <= '0;
`endif
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_strip_q <= '0;
            resp_used_q  <= '0;
            rd_en_q      <= 1'b0;
            for (int i = 0; i < int'(LANES); i++) begin
                rd_addr_q[i] <= '0;
            end
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        op_q        <= req_op;
                        size_q      <= req_size;
                        strip_q     <= req_strip;
                        found_q     <= 1'b0;
                        if ((req_size == '0) ||
                            (req_op && ((req_strip == '0) || (GW'(req_strip) > LAST_STRIP)))) begin
                            resp_valid_q <= 1'b1;
                            resp_ok_q    <= 1'b0;
                            resp_strip_q <= '0;
                            resp_used_q  <= '0;
                            state_q      <= S_RESP;
                        end else if (req_op) begin
                            rd_en_q <= 1'b1;
                            for (int i = 0; i < int'(LANES); i++) begin
                                rd_addr_q[i] <= req_strip;
                            end
                            state_q <= S_RD;
                        end else if (!cap_valid_q) begin
                            rd_en_q <= 1'b1;
                            for (int i = 0; i < int'(LANES); i++) begin
                                rd_addr_q[i] <= '0;
                            end
                            state_q <= S_CAP_RD;
                        end else begin
                            g_q     <= FIRST_BASE;
                            rd_en_q <= 1'b1;
                            for (int i = 0; i < int'(LANES); i++) begin
                                rd_addr_q[i] <= lane_ram_addr(FIRST_BASE, i);
                            end
                            state_q <= S_RD;
                        end
                    end
                end

                S_CAP_RD: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_CAP_WT;
                end

                S_CAP_WT: begin
                    cap_q       <= ram_data_out1;
                    cap_valid_q <= 1'b1;
                    g_q         <= FIRST_BASE;
                    rd_en_q     <= 1'b1;
                    for (int i = 0; i < int'(LANES); i++) begin
                        rd_addr_q[i] <= lane_ram_addr(FIRST_BASE, i);
                    end
                    state_q <= S_RD;
                end

                S_RD: begin
                    rd_en_q <= 1'b0;
                    for (int i = 0; i < int'(LANES); i++) begin
                        rd_addr_q[i] <= '0;
                    end
                    state_q <= S_EVAL;
                end

                S_EVAL: begin
                    if (op_q) begin
                        found_q     <= 1'b1;
                        sel_strip_q <= strip_q;
                        sel_used_q  <= free_new_c;
                        wr_en_q     <= 1'b1;
                        wr_addr_q   <= strip_q;
                        wr_data_q   <= free_new_c;
                        state_q     <= S_WRITE;
                    end else begin
`ifdef STRIP_ALLOC_BEST_FIT_EN
                        if (take_best_c) begin
                            found_q     <= 1'b1;
                            sel_strip_q <= ADDR_WIDTH'(pick_addr_c);
                            sel_used_q  <= DATA_WIDTH'(pick_sum_c);
                            best_left_q <= pick_left_c;
                        end
                        state_q <= S_ADV;
`else
                        if (any_fit_c) begin
                            found_q     <= 1'b1;
                            sel_strip_q <= ADDR_WIDTH'(pick_addr_c);
                            sel_used_q  <= DATA_WIDTH'(pick_sum_c);
                            wr_en_q     <= 1'b1;
                            wr_addr_q   <= ADDR_WIDTH'(pick_addr_c);
                            wr_data_q   <= DATA_WIDTH'(pick_sum_c);
                            state_q     <= S_WRITE;
                        end else begin
                            state_q <= S_ADV;
                        end
`endif
                    end
                end

                // Step to the next group, or close the scan with the best candidate.
                S_ADV: begin
                    g_q <= g_next_c;
                    if (g_next_c <= LAST_STRIP) begin
                        rd_en_q <= 1'b1;
                        for (int i = 0; i < int'(LANES); i++) begin
                            rd_addr_q[i] <= lane_ram_addr(g_next_c, i);
                        end
                        state_q <= S_RD;
                    end else begin
                        wr_en_q   <= found_q;
                        wr_addr_q <= found_q ? sel_strip_q : '0;
                        wr_data_q <= found_q ? sel_used_q : '0;
                        state_q   <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    wr_en_q      <= 1'b0;
                    wr_addr_q    <= '0;
                    wr_data_q    <= '0;
                    resp_valid_q <= 1'b1;
                    resp_ok_q    <= found_q;
                    resp_strip_q <= found_q ? sel_strip_q : '0;
                    resp_used_q  <= found_q ? sel_used_q : '0;
                    state_q      <= S_RESP;
                end

                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_strip_alloc_ctrl.sv
// tb_strip_alloc_ctrl: scoreboard bench for strip_alloc_ctrl with a RAM model
// and a strip-level reference of occupancy, allocation choice and latency.
module tb_strip_alloc_ctrl;

    localparam int CAP        = 128;
    localparam int NUM_STRIPS = 13;
`ifdef STRIP_ALLOC_BEST_FIT_EN
    localparam bit BEST = 1'b1;
`else
    localparam bit BEST = 1'b0;
`endif

    typedef struct {
        bit ok;
        int strip;
        int used;
        int lat;
        int c0;
    } exp_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_op = 1'b0;
    logic [7:0] req_size = '0;
    logic [3:0] req_strip = '0;
    logic       resp_valid;
    logic       resp_ok;
    logic [3:0] resp_strip;
    logic [7:0] resp_used;
    logic       ram_read_en;
    logic [3:0] ram_addr_read1, ram_addr_read2, ram_addr_read3;
    logic [7:0] ram_data_out1 = '0, ram_data_out2 = '0, ram_data_out3 = '0;
    logic       ram_write_en;
    logic [3:0] ram_addr_write;
    logic [7:0] ram_data_in;

    logic       pre_en = 1'b0;
    logic [3:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    logic [7:0] mem [16];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   cap_reads = 0;
    int   exp_caps = 0;
    bit   cap_loaded = 1'b0;
    int   occ [16];
    exp_t exq [$];
    wr_t  wq [$];
    exp_t mon_e;
    wr_t  mon_w;

    strip_alloc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_size       (req_size),
        .req_strip      (req_strip),
        .resp_valid     (resp_valid),
        .resp_ok        (resp_ok),
        .resp_strip     (resp_strip),
        .resp_used      (resp_used),
        .ram_read_en    (ram_read_en),
        .ram_addr_read1 (ram_addr_read1),
        .ram_addr_read2 (ram_addr_read2),
        .ram_addr_read3 (ram_addr_read3),
        .ram_data_out1  (ram_data_out1),
        .ram_data_out2  (ram_data_out2),
        .ram_data_out3  (ram_data_out3),
        .ram_write_en   (ram_write_en),
        .ram_addr_write (ram_addr_write),
        .ram_data_in    (ram_data_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Occupancy RAM: registered reads, one write port, bench backdoor preload.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (ram_write_en) mem[ram_addr_write] <= ram_data_in;
        if (ram_read_en) begin
            ram_data_out1 <= mem[ram_addr_read1];
            ram_data_out2 <= mem[ram_addr_read2];
            ram_data_out3 <= mem[ram_addr_read3];
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each response and each RAM write.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_read_en && ram_addr_read1 == 4'd0 && ram_addr_read2 == 4'd0 &&
                ram_addr_read3 == 4'd0)
                cap_reads++;
            if (resp_valid) begin
                if (exq.size() == 0) begin
                    chk("unexpected_resp", int'(resp_valid), 0);
                end else begin
                    mon_e = exq.pop_front();
                    chk("resp_ok", int'(resp_ok), int'(mon_e.ok));
                    chk("resp_strip", int'(resp_strip), mon_e.strip);
                    chk("resp_used", int'(resp_used), mon_e.used);
                    chk("latency", cyc - mon_e.c0, mon_e.lat);
                end
            end
            if (ram_write_en) begin
                chk("wr_rd_exclusive", int'(ram_read_en), 0);
                chk("wr_addr_nonzero", int'(ram_addr_write != 4'd0), 1);
                if (wq.size() == 0) begin
                    chk("unexpected_write", int'(ram_write_en), 0);
                end else begin
                    mon_w = wq.pop_front();
                    chk("wr_addr", int'(ram_addr_write), mon_w.addr);
                    chk("wr_data", int'(ram_data_in), mon_w.data);
                end
            end
        end
    end

    // Reference model: result, RAM write and latency of one request.
    task automatic model(input bit op, input int size, input int strip, output exp_t e);
        int extra, best, best_left, left, nv;
        e = '{ok: 1'b0, strip: 0, used: 0, lat: 1, c0: 0};
        if (size == 0 || (op && (strip == 0 || strip > NUM_STRIPS))) return;
        if (op) begin
            nv = (occ[strip] > size) ? occ[strip] - size : 0;
            occ[strip] = nv;
            wq.push_back('{addr: strip, data: nv});
            e = '{ok: 1'b1, strip: strip, used: nv, lat: 4, c0: 0};
            return;
        end
        extra = cap_loaded ? 0 : 2;
        if (!cap_loaded) exp_caps++;
        cap_loaded = 1'b1;
        best = 0;
        best_left = CAP + 1;
        for (int s = 1; s <= NUM_STRIPS; s++) begin
            if (occ[s] + size <= CAP) begin
                left = CAP - occ[s] - size;
                if (BEST) begin
                    if (left < best_left) begin
                        best = s;
                        best_left = left;
                    end
                end else if (best == 0) begin
                    best = s;
                end
            end
        end
        if (best == 0) begin
            e = '{ok: 1'b0, strip: 0, used: 0, lat: 17 + extra, c0: 0};
        end else begin
            occ[best] += size;
            wq.push_back('{addr: best, data: occ[best]});
            e = '{ok: 1'b1, strip: best, used: occ[best],
                  lat: (BEST ? 17 : 3 * ((best - 1) / 3) + 4) + extra, c0: 0};
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", int'(req_ready), 1);
    endtask

    task automatic issue(input bit op, input int size, input int strip);
        exp_t e;
        int   n;
        wait_ready();
        model(op, size, strip, e);
        e.c0 = cyc;
        exq.push_back(e);
        req_valid = 1'b1;
        req_op    = op;
        req_size  = 8'(size);
        req_strip = 4'(strip);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (exq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("resp_timeout", exq.size(), 0);
        exq.delete();
        @(negedge clk);
        chk("hold_ok", int'(resp_ok), int'(e.ok));
        chk("hold_strip", int'(resp_strip), e.strip);
        chk("hold_used", int'(resp_used), e.used);
    endtask

    task automatic preload(input int addr, input int data);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = 4'(addr);
        pre_data = 8'(data);
        @(negedge clk);
        pre_en = 1'b0;
        occ[addr] = data;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, op, size;
        // Reset with RAM initialisation: capacity in entry 0, strips empty.
        for (int a = 0; a < 16; a++) preload(a, (a == 0) ? CAP : 0);
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_ok", int'(resp_ok), 0);
        chk("rst_resp_strip", int'(resp_strip), 0);
        chk("rst_resp_used", int'(resp_used), 0);
        chk("rst_read_en", int'(ram_read_en), 0);
        chk("rst_write_en", int'(ram_write_en), 0);
        chk("rst_addr_write", int'(ram_addr_write), 0);
        rst = 1'b0;

        // First alloc after reset loads capacity.
        issue(1'b0, 40, 0);
        chk("cap_read_first", cap_reads, 1);
        issue(1'b1, 40, 1);
        for (int k = 0; k < 5; k++) issue(1'b0, 128, 0);
        issue(1'b0, 100, 0);
        issue(1'b0, 129, 0);

        // Reset during the second group's read abandons the request.
        wait_ready();
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_size  = 8'd100;
        req_strip = 4'd0;
        c0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_cycle", cyc - c0, 4);
        chk("mid_read_en", int'(ram_read_en), 1);
        chk("mid_read_addr1", int'(ram_addr_read1), 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cap_loaded = 1'b0;
        chk("mid_req_ready", int'(req_ready), 1);
        chk("mid_resp_valid", int'(resp_valid), 0);
        chk("mid_write_en", int'(ram_write_en), 0);
        repeat (20) @(negedge clk);

        // Free saturation and immediate failures.
        issue(1'b1, 78, 2);
        issue(1'b1, 80, 2);
        issue(1'b1, 10, 0);
        issue(1'b1, 10, 14);
        issue(1'b1, 10, 15);
        issue(1'b0, 0, 0);
        issue(1'b1, 0, 3);
        issue(1'b0, 20, 0);

        // Strip selection with a sparse occupancy map.
        for (int s = 1; s <= NUM_STRIPS; s++) preload(s, (s == 3) ? 100 : (s == 9) ? 110 : 0);
        issue(1'b0, 18, 0);

        // Randomized mix of allocs, frees and illegal requests.
        for (int t = 0; t < 220; t++) begin
            op   = int'($urandom_range(0, 1));
            size = (op == 1) ? int'($urandom_range(1, 90)) : int'($urandom_range(1, 70));
            if ($urandom_range(0, 9) == 0) size = 0;
            issue(op[0], size, int'($urandom_range(0, 15)));
        end

        repeat (5) @(negedge clk);
        chk("write_queue_left", wq.size(), 0);
        chk("cap_reads", cap_reads, exp_caps);
        for (int s = 1; s <= NUM_STRIPS; s++) chk("ram_final", int'(mem[s]), occ[s]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/strip_alloc_ctrl.md
Name: strip_alloc_ctrl

Overview:
Initiator-side controller for the 14-entry strip occupancy RAM (3 read ports, 1 write port). It accepts allocate/free requests from the placement datapath and reads strip occupancy three strips at a time. It selects a strip, writes back the updated occupancy and returns a one-cycle response. Entry 0 holds strip capacity (128 after reset) and is never written; entries 1..13 hold the used amount per strip.

Parameters:
ADDR_WIDTH, 4, RAM address width
DATA_WIDTH, 8, occupancy/capacity width
NUM_STRIPS, 13, valid strip addresses 1..NUM_STRIPS

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE
req_op  input  1  0 = allocate, 1 = free
req_size  input  DATA_WIDTH  amount to allocate/free
req_strip  input  ADDR_WIDTH  target strip for free (ignored for allocate)
resp_valid  output  1  one-cycle response pulse, no backpressure
resp_ok  output  1  1 = success
resp_strip  output  ADDR_WIDTH  chosen/freed strip, 0 on failure
resp_used  output  DATA_WIDTH  new occupancy of resp_strip, 0 on failure
ram_read_en  output  1  to RAM read_en
ram_addr_read1/2/3  output  ADDR_WIDTH each  to RAM read addresses
ram_data_out1/2/3  input  DATA_WIDTH each  RAM registered read data
ram_write_en  output  1  to RAM write_en
ram_addr_write  output  ADDR_WIDTH  to RAM write address, never 0 when ram_write_en=1
ram_data_in  output  DATA_WIDTH  to RAM write data

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous, active-high.
- Reset: all outputs 0 except req_ready=1. State goes to IDLE, cap_valid=0, no RAM write issued. Reset mid-operation abandons the request with no response.
- RAM timing contract: addresses and read_en presented in cycle N -> data valid on ram_data_out* in cycle N+1. read_en and write_en are never asserted together.
- States: IDLE, CAP_RD, CAP_WT, RD, EVAL, WRITE, RESP.
- IDLE: on req_valid, capture op/size/strip and drop req_ready.
  - Immediate fail (RESP next, no RAM access) if req_size==0, or if op=free and req_strip is 0 or >NUM_STRIPS.
  - Otherwise: alloc with cap_valid=0 -> CAP_RD; alloc with cap_valid=1 -> RD with group base g=1; free -> RD with all three addresses = req_strip.
- CAP_RD: read_en with all addresses 0 -> CAP_WT, which latches cap from port 1, sets cap_valid=1 and goes to RD. cap_valid persists until reset.
- RD: read_en with addresses g, g+1, g+2 -> EVAL.
  - Any address >NUM_STRIPS is driven 0 and that lane is marked invalid.
- EVAL, alloc:
  - Lane fits if valid and used+size <= cap, computed in DATA_WIDTH+1 bits (no wrap).
  - First fit: lowest fitting lane wins -> WRITE.
  - No fit: g+=3 and go to RD if g<=NUM_STRIPS, else fail -> RESP.
- EVAL, free: new = port1 - size, saturating at 0 -> WRITE.
- WRITE: one cycle of write_en with addr = chosen strip and data = new value; set resp_ok=1, resp_strip, resp_used -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE, req_ready=1.
  - resp_ok/strip/used hold their values until the next response.
- Latency from accept to resp_valid:
  - Alloc hit in group k (0-based, cap loaded): 3k+4 cycles. Add 2 cycles for the first alloc after reset.
  - Alloc fail with cap loaded: 17 cycles.
  - Free: 4 cycles. Immediate fail: 1 cycle.
- Requests arriving while req_ready=0 are not accepted and must be held by the requester.

Optional Feature:
- Macro: STRIP_ALLOC_BEST_FIT_EN.
- Defined: alloc scans all groups (5 RD/EVAL pairs) and tracks the minimum leftover cap-(used+size). Ties go to the lowest strip index, then WRITE. Alloc latency is fixed at 17 cycles for both hit and fail (cap loaded).
- Undefined: first fit as above.

Test Plan:
- Reset, then alloc size 40 -> CAP_RD reads addr 0, resp_ok=1, strip=1, used=40, RAM[1]=40, latency 6.
- Preload RAM[1..5]=128 (via frees/allocs), alloc 100 -> strips 1-5 skipped, strip 6, used=100, latency 7 (cap loaded).
- Alloc 129 with cap=128 -> all 5 groups scanned, resp_ok=0, strip=0, used=0, no write_en pulse, latency 17.
- RAM[2]=50, free strip 2 size 80 -> used saturates to 0, RAM[2]=0. Free strip 0 -> fail in 1 cycle. Free strip 14 -> fail in 1 cycle.
- Assert rst during RD of the second group -> no response, no write, req_ready=1 next cycle, next alloc re-reads cap.
- STRIP_ALLOC_BEST_FIT_EN with RAM[3]=100, RAM[9]=110, others 0, alloc 18 -> strip 9, used=128, latency 17.
